// File: rtl/irq_pkg.sv
// Shared types for the interrupt front end: line count, id width, FSM states and a one-hot test.
package irq_pkg;

    localparam int IRQ_N    = 8;
    localparam int IRQ_ID_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } irq_state_e;

    // True when exactly one bit is set; clearing the lowest set bit must leave zero.
    function automatic logic is_onehot(input logic [IRQ_N-1:0] v);
        logic [IRQ_N-1:0] low_cleared;
        low_cleared = v & (v - {{(IRQ_N-1){1'b0}}, 1'b1});
        return (v != '0) && (low_cleared == '0);
    endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary index encoder; input is assumed one-hot.
module onehot_to_bin #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] onehot,
    output logic [W-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                bin = bin | W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt front end: synchronizes request lines into a pending register, drives the masked
// pending vector to the priority stage and hands the winner to the CPU under req/ack.
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter int N           = IRQ_N,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        irq_in,
    input  logic [N-1:0]        edge_mode,
    input  logic [N-1:0]        mask,
    output logic [N-1:0]        pend_vec,
    input  logic [N-1:0]        sel_onehot,
    input  logic                sel_valid,
    output logic                irq_req,
    output logic [IRQ_ID_W-1:0] irq_id,
    input  logic                irq_ack,
    output logic                err,
    output irq_state_e          fsm_state
);

    // CPU handshake: irq_req rises with irq_id already stable and both hold until the cycle
    // irq_ack is sampled high; irq_req is low after that edge and stays low at least one cycle.

    logic [N-1:0]         sync_q [SYNC_STAGES];
    logic [N-1:0]         s;
    logic [N-1:0]         s_d;
    logic [SYNC_STAGES:0] prime_q;
    logic                 edge_en;
    logic [N-1:0]         set_vec;
    logic [N-1:0]         clr_vec;
    logic [N-1:0]         pending;

    irq_state_e           state_q, state_d;
    logic [N-1:0]         svc_q, svc_d;
    logic                 req_q, req_d;
    logic [IRQ_ID_W-1:0]  id_q, id_d;
    logic                 err_q, err_d;
    logic                 settle_q;
    logic [IRQ_ID_W-1:0]  sel_id;

    assign s = sync_q[SYNC_STAGES-1];

    // Edge detection waits until s and s_d both hold real samples, so lines already high
    // at reset release do not look like rising edges.
    assign edge_en = prime_q[SYNC_STAGES];
    assign set_vec = (edge_mode & s & ~s_d & {N{edge_en}}) | (~edge_mode & s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            s_d      <= '0;
            prime_q  <= '0;
            pending  <= '0;
            pend_vec <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_d      <= s;
            prime_q  <= {prime_q[SYNC_STAGES-1:0], 1'b1};
            pending  <= (pending & ~clr_vec) | set_vec;
            pend_vec <= pending & ~mask;
        end
    end

    onehot_to_bin #(.N(N), .W(IRQ_ID_W)) u_enc (
        .onehot (sel_onehot),
        .bin    (sel_id)
    );

    // pend_vec still shows the serviced bit for one cycle after ack; settle_q blocks that cycle.
    always_comb begin
        state_d = state_q;
        svc_d   = svc_q;
        req_d   = req_q;
        id_d    = id_q;
        err_d   = err_q;
        clr_vec = '0;
        case (state_q)
            IDLE: begin
                if (irq_ack) begin
                    err_d = 1'b1;
                end
                if (sel_valid && !settle_q) begin
                    if (is_onehot(sel_onehot) && ((sel_onehot & ~pend_vec) == '0)) begin
                        svc_d   = sel_onehot;
                        id_d    = sel_id;
                        req_d   = 1'b1;
                        state_d = REQ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (irq_ack) begin
                    clr_vec = svc_q;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            svc_q    <= '0;
            req_q    <= 1'b0;
            id_q     <= '0;
            err_q    <= 1'b0;
            settle_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            svc_q    <= svc_d;
            req_q    <= req_d;
            id_q     <= id_d;
            err_q    <= err_d;
            settle_q <= (state_q == REQ) && irq_ack;
        end
    end

    assign irq_req   = req_q;
    assign irq_id    = id_q;
    assign err       = err_q;
    assign fsm_state = state_q;

endmodule
